// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
//   Shared definitions for the sequential restoring divider: default operand
//   widths and the controller state encoding.
// -----------------------------------------------------------------------------
package seq_divider_pkg;

  localparam int DW_DEFAULT = 8;  // dividend / quotient width
  localparam int VW_DEFAULT = 4;  // divisor / remainder width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage : seq_divider_pkg

// File: rtl/seq_divider_sub_stage.sv
// -----------------------------------------------------------------------------
// seq_divider_sub_stage
//   One restoring-division step: computes t - {1'b0, d} through a ripple
//   borrow chain of one-bit subtract cells. The same chain provides the
//   compare result: a clear borrow-out means t >= d.
//
// Ports:
//   t     in  VW+1  trial partial remainder
//   d     in  VW    divisor
//   diff  out VW+1  t - d (meaningful only when ge = 1)
//   ge    out 1     t >= d
// -----------------------------------------------------------------------------
module seq_divider_sub_stage #(
  parameter int VW = 4
) (
  input  logic [VW:0]   t,
  input  logic [VW-1:0] d,
  output logic [VW:0]   diff,
  output logic          ge
);

  logic [VW+1:0] borrow;
  logic [VW:0]   d_ext;

  assign d_ext     = {1'b0, d};
  assign borrow[0] = 1'b0;

  for (genvar i = 0; i <= VW; i++) begin : g_cell
    assign diff[i]     = t[i] ^ d_ext[i] ^ borrow[i];
    assign borrow[i+1] = (~t[i] & d_ext[i]) | (~(t[i] ^ d_ext[i]) & borrow[i]);
  end

  assign ge = ~borrow[VW+1];

endmodule : seq_divider_sub_stage

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Sequential restoring divider. An accepted start captures the operands,
//   then one quotient bit is produced per clock for DW clocks, followed by a
//   single FIN cycle that pulses done. A zero divisor skips the iterations
//   and reports div_by_zero with an all-ones quotient.
//
// Ports:
//   clk          in  1   rising-edge clock
//   rst          in  1   asynchronous, active-high reset
//   start        in  1   request pulse, honoured only in IDLE
//   dividend     in  DW  unsigned dividend, captured on accepted start
//   divisor      in  VW  unsigned divisor, captured on accepted start
//   busy         out 1   iterations in progress
//   done         out 1   one-cycle pulse; results valid from this cycle
//   quotient     out DW  unsigned quotient (held until the next done)
//   remainder    out VW  unsigned remainder (held until the next done)
//   div_by_zero  out 1   captured divisor was zero
// -----------------------------------------------------------------------------
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int VW = VW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  state_t        state_q, state_d;
  logic [DW-1:0] q_q;       // dividend shifting out MSB-first, quotient in LSB
  logic [VW-1:0] d_q;       // captured divisor
  logic [VW:0]   r_q;       // partial remainder
  logic [CW-1:0] cnt_q;     // remaining iterations minus one

  logic          busy_q, done_q, dbz_q;
  logic [DW-1:0] quotient_q;
  logic [VW-1:0] remainder_q;

  logic [VW:0]   t_val;
  logic [VW:0]   sub_diff;
  logic          sub_ge;
  logic [VW:0]   r_next;
  logic [DW-1:0] q_next;

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  assign t_val  = {r_q[VW-1:0], q_q[DW-1]};
  assign r_next = sub_ge ? sub_diff : t_val;
  assign q_next = {q_q[DW-2:0], sub_ge};

  seq_divider_sub_stage #(.VW(VW)) u_sub_stage (
    .t    (t_val),
    .d    (d_q),
    .diff (sub_diff),
    .ge   (sub_ge)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns state_d; otherwise a latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = (divisor == '0) ? ST_FIN : ST_RUN;
      ST_RUN:  if (cnt_q == '0) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and handshake flags. busy/done are registered from the
  // next state so they are clean flop outputs aligned with state_q.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_FIN);
    end
  end

  // ---------------------------------------------------------------------------
  // Operand, iteration and result registers. Results are loaded on the edge
  // that enters FIN, so they are valid in the same cycle as done.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register here is a plain flop, so all of them are cleared.
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            q_q   <= dividend;
            d_q   <= divisor;
            r_q   <= '0;
            cnt_q <= CW'(DW - 1);
            if (divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= '0;
              dbz_q       <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          q_q   <= q_next;
          r_q   <= r_next;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            quotient_q  <= q_next;
            remainder_q <= r_next[VW-1:0];
            dbz_q       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // The partial remainder stays below the divisor, so its top bit is only
  // headroom for the shifted trial value and must never be set.
  always @(posedge clk) begin
    if (!rst && state_q == ST_RUN) assert (r_q[VW] == 1'b0);
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Directed self-checking bench for seq_divider (DW=8, VW=4). Inputs are
//   driven and outputs sampled on the falling edge; negedge k after the
//   accepting rising edge T is cycle T+k.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'h00;
  logic [3:0] divisor = 4'h0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  seq_divider #(.DW(8), .VW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Drive one start pulse and return the number of falling edges until done
  // (1 = cycle T+1). Gives up at 40.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, output int lat);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = 8'h00; divisor = 4'h0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 1'b0; dividend = 8'h00; divisor = 4'h0; end
      n_checks++;
      if (busy !== (k <= 8) || done !== (k == 9)) begin
        n_fail++;
        $display("FAIL basic_handshake cycle T+%0d: got busy=%b done=%b, want busy=%b done=%b",
                 k, busy, done, k <= 8, k == 9);
      end
      if (k == 9) begin
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== {8'd28, 4'd4, 1'b0}) begin
          n_fail++;
          $display("FAIL basic_200_7: got q=%0d r=%0d dbz=%b, want q=28 r=4 dbz=0",
                   quotient, remainder, div_by_zero);
        end
      end
    end
  endtask

  task automatic test_extremes();
    logic [7:0] ta [3] = '{8'd255, 8'd5, 8'd0};
    logic [3:0] tb [3] = '{4'd1, 4'd9, 4'd15};
    logic [7:0] eq [3] = '{8'd255, 8'd0, 8'd0};
    logic [3:0] er [3] = '{4'd0, 4'd5, 4'd0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], lat);
      n_checks++;
      if (lat != 9 || {quotient, remainder, div_by_zero} !== {eq[i], er[i], 1'b0}) begin
        n_fail++;
        $display("FAIL extreme_%0d_%0d: got lat=%0d q=%0d r=%0d dbz=%b, want lat=9 q=%0d r=%0d dbz=0",
                 ta[i], tb[i], lat, quotient, remainder, div_by_zero, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_zero_divisor();
    int lat;
    run_op(8'd100, 4'd0, lat);
    n_checks++;
    if (lat != 1 || {quotient, remainder, div_by_zero} !== {8'hFF, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_div_100_0: got lat=%0d q=%0h r=%0d dbz=%b, want lat=1 q=ff r=0 dbz=1",
               lat, quotient, remainder, div_by_zero);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({done, quotient, div_by_zero} !== {1'b0, 8'hFF, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_div_hold: got done=%b q=%0h dbz=%b, want done=0 q=ff dbz=1",
               done, quotient, div_by_zero);
    end
    run_op(8'd100, 4'd10, lat);
    n_checks++;
    if (lat != 9 || {quotient, remainder, div_by_zero} !== {8'd10, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL after_zero_100_10: got lat=%0d q=%0d r=%0d dbz=%b, want lat=9 q=10 r=0 dbz=0",
               lat, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_start_while_busy();
    int n_done = 0;
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      start = (k == 3);
      dividend = (k == 3) ? 8'd99 : 8'd0;
      divisor  = (k == 3) ? 4'd3  : 4'd0;
      if (done === 1'b1) n_done++;
      if (k == 9) begin
        n_checks++;
        if ({done, quotient, remainder} !== {1'b1, 8'd28, 4'd4}) begin
          n_fail++;
          $display("FAIL busy_start_result: got done=%b q=%0d r=%0d, want done=1 q=28 r=4",
                   done, quotient, remainder);
        end
      end
    end
    n_checks++;
    if (n_done != 1 || {quotient, remainder} !== {8'd28, 4'd4}) begin
      n_fail++;
      $display("FAIL busy_start_ignored: got %0d done pulses q=%0d r=%0d, want 1 pulse q=28 r=4",
               n_done, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid_run();
    int n_done = 0;
    int lat;
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0; dividend = 8'd0; divisor = 4'd0;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    n_checks++;
    if (n_done != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort: got %0d done pulses busy=%b, want 0 pulses busy=0", n_done, busy);
    end
    run_op(8'd143, 4'd11, lat);
    n_checks++;
    if (lat != 9 || {quotient, remainder, div_by_zero} !== {8'd13, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL after_reset_143_11: got lat=%0d q=%0d r=%0d dbz=%b, want lat=9 q=13 r=0 dbz=0",
               lat, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int last_done = -1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(8'(a), 4'(b), lat);
        n_checks++;
        if (done !== 1'b1 || int'(quotient) != a / b || int'(remainder) != a % b ||
            int'(quotient) * b + int'(remainder) != a || div_by_zero !== 1'b0) begin
          n_fail++;
          $display("FAIL sweep_%0d_%0d: got done=%b q=%0d r=%0d dbz=%b, want done=1 q=%0d r=%0d dbz=0",
                   a, b, done, quotient, remainder, div_by_zero, a / b, a % b);
        end
        if (last_done >= 0) begin
          n_checks++;
          if (cyc - last_done != 10) begin
            n_fail++;
            $display("FAIL sweep_spacing_%0d_%0d: got %0d cycles between done, want 10",
                     a, b, cyc - last_done);
          end
        end
        last_done = cyc;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_zero_divisor();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seq_divider

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider; the inverse of the team's 4x4 combinational multiplier.
- Takes an 8-bit dividend and a 4-bit divisor, then iterates one quotient bit per clock.
- Returns quotient and remainder with a start/done handshake.
- Used wherever an 8-bit product must be split back into its factors, or where a general small integer division is needed in the arithmetic datapath.

Parameters:
- DW, 8, dividend and quotient width. Must satisfy DW >= VW.
- VW, 4, divisor and remainder width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only when busy=0
- dividend  input  DW  unsigned dividend; captured on accepted start
- divisor  input  VW  unsigned divisor; captured on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; quotient, remainder and div_by_zero are valid from this cycle
- quotient  output  DW  unsigned quotient
- remainder  output  VW  unsigned remainder
- div_by_zero  output  1  set with done when the captured divisor was 0

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. All internal registers are cleared.
- States:
  - IDLE
  - RUN: counter counts DW-1 down to 0
  - FIN
- IDLE, start=1, divisor!=0:
  - Capture dividend into a shift register Q and divisor into register D.
  - Clear partial remainder R (VW+1 bits).
  - Load counter=DW-1; go to RUN; busy=1 from the next cycle.
- IDLE, start=1, divisor==0:
  - Go to FIN directly; no iterations.
  - Results: quotient={DW{1'b1}}, remainder=0, div_by_zero=1.
- RUN, each cycle:
  - T = {R[VW-1:0], Q[DW-1]}.
  - If T >= {1'b0,D}: R <= T-D and shift 1 into Q LSB. Otherwise: R <= T and shift 0 into Q LSB.
  - Decrement counter; when counter==0, go to FIN.
- FIN (one cycle):
  - done=1, busy=0.
  - quotient<=Q, remainder<=R[VW-1:0], div_by_zero<=0, except on the zero-divisor path (values above).
  - Go to IDLE.
- Outputs are registered. quotient/remainder/div_by_zero hold their values until the next FIN.
- Latency: start accepted at edge T gives done high in cycle T+DW+1 (T+9 for default DW). Zero-divisor path: done in cycle T+1.
- Throughput: one operation per DW+2 cycles. start in the FIN cycle is ignored (not accepted); the next accept is in IDLE.
- start while busy=1: ignored. Captured operands are unaffected, and no queueing occurs.
- Operand inputs are don't-care except in the accepting cycle.
- Reset asserted mid-RUN: immediate return to reset values. No done pulse is produced for the aborted operation.
- Arithmetic rules:
  - R never exceeds D-1 after a subtract step, so VW+1 bits suffice.
  - The compare and subtract share one (VW+1)-bit borrow chain: borrow-out=0 means T>=D.
- Invariant on every non-zero-divisor done: dividend == quotient*divisor + remainder, and remainder < divisor.

Decomposition:
- Shared header (Verilog include): state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_FIN=2'd2, plus default widths DW/VW.
- One natural combinational sub-module: sub_stage.
  - Inputs: (VW+1)-bit t and VW-bit d.
  - Outputs: difference, and ge = ~borrow.
  - Built as a ripple borrow chain of one-bit subtract cells.
- Top-level seq_divider holds the FSM, counter, Q/R/D registers and output registers.

Test Plan:
- Basic division: dividend=200, divisor=7, start at T -> done at T+9 with quotient=28, remainder=4, div_by_zero=0; busy=1 for cycles T+1..T+8.
- Extremes: 255/1 -> quotient=255, remainder=0. 5/9 -> quotient=0, remainder=5. 0/15 -> quotient=0, remainder=0.
- Zero divisor: 100/0 -> done at T+1, quotient=8'hFF, remainder=0, div_by_zero=1. A following 100/10 -> quotient=10, remainder=0, div_by_zero=0.
- start pulsed at T+3 with 99/3 during the 200/7 operation -> ignored; result stays 28 r4 and no second done occurs.
- Reset asserted at T+4 of the 200/7 operation -> outputs 0 immediately, no done. A new 143/11 after release -> quotient=13, remainder=0.
- Exhaustive sweep, all 256x15 non-zero operand pairs, back-to-back starts -> invariant holds for every pair, with done spacing exactly DW+2 cycles.
